bmul_seq: RTL and testbench

- Parametrised, area-lean successor to the single-cycle registered binary multiplier.
- Multiplies two INWD-bit operands by iterative radix-2 shift-add, one partial product per clock.
- Valid/ready handshakes on both sides, so it can sit between stream stages in the binary reference datapath that the stochastic units are checked against.
- Unsigned by default; signed mode is compile-time optional.

---
 rtl/bmul_pkg.sv | 15 +
 rtl/bmul_ctrl.sv | 77 +++++++
 rtl/bmul_seq.sv | 109 ++++++++++
 tb/tb_bmul_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bmul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package bmul_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int unsigned BMUL_INWD_DEF = 8;
  localparam int unsigned BMUL_MAXW     = 64;

  // Conditional two's-complement negate; callers size in/out with casts.
  function automatic logic [BMUL_MAXW-1:0] bmul_cneg(input logic [BMUL_MAXW-1:0] x,
                                                     input logic                 neg);
    return neg ? (~x + BMUL_MAXW'(1)) : x;
  endfunction

endpackage

// File: rtl/bmul_ctrl.sv
// Sequencer for bmul_seq: IDLE/BUSY/DONE FSM, iteration counter and handshake strobes.
module bmul_ctrl
  import bmul_pkg::*;
#(
  parameter  int unsigned INWD = BMUL_INWD_DEF,
  localparam int unsigned CNTW = $clog2(INWD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            ready_in,
  output logic            ready_out,
  output logic            valid_out,
  output logic            load,
  output logic            step,
  output logic            done,
  output logic [CNTW-1:0] cnt
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    ready_out = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is held low for as long as reset is asserted.
        ready_out = !rst;
        load      = valid_in && !rst;
        if (load) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(INWD - 1)) begin
          done    = 1'b1;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (valid_q && ready_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_out = valid_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/bmul_seq.sv
// Radix-2 shift-add multiplier, one partial product per clock, valid/ready on both sides.
// Define BMUL_SIGNED_EN to add the per-operation iSigned two's-complement mode.
module bmul_seq
  import bmul_pkg::*;
#(
  parameter  int unsigned INWD = BMUL_INWD_DEF,
  localparam int unsigned CNTW = $clog2(INWD),
  localparam int unsigned PW   = 2 * INWD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iValid,
  output logic            oReady,
  input  logic [INWD-1:0] iA,
  input  logic [INWD-1:0] iB,
`ifdef BMUL_SIGNED_EN
  input  logic            iSigned,
`endif
  output logic            oValid,
  input  logic            iReady,
  output logic [PW-1:0]   oC
);

  logic            load, step, done;
  logic [CNTW-1:0] cnt;

  logic [INWD-1:0] mcand_q, mcand_d;
  logic [INWD-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   oc_q, oc_d;
  logic [PW-1:0]   addend_c, sum_c;
`ifdef BMUL_SIGNED_EN
  logic            neg_q, neg_d;
  logic            sa_c, sb_c;
`endif

  bmul_ctrl #(.INWD(INWD)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (iValid),
    .ready_in  (iReady),
    .ready_out (oReady),
    .valid_out (oValid),
    .load      (load),
    .step      (step),
    .done      (done),
    .cnt       (cnt)
  );

  assign addend_c = mplier_q[0] ? (PW'(mcand_q) << cnt) : '0;
  assign sum_c    = acc_q + addend_c;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    oc_d     = oc_q;
`ifdef BMUL_SIGNED_EN
    neg_d    = neg_q;
    sa_c     = iSigned && iA[INWD-1];
    sb_c     = iSigned && iB[INWD-1];
`endif
    if (load) begin
`ifdef BMUL_SIGNED_EN
      // Magnitudes fit in INWD unsigned bits, including -2^(INWD-1).
      mcand_d  = INWD'(bmul_cneg(BMUL_MAXW'($signed(iA)), sa_c));
      mplier_d = INWD'(bmul_cneg(BMUL_MAXW'($signed(iB)), sb_c));
      neg_d    = sa_c ^ sb_c;
`else
      mcand_d  = iA;
      mplier_d = iB;
`endif
      acc_d    = '0;
    end else if (step) begin
      acc_d    = sum_c;
      mplier_d = mplier_q >> 1;
      if (done) begin
`ifdef BMUL_SIGNED_EN
        oc_d = PW'(bmul_cneg(BMUL_MAXW'(sum_c), neg_q));
`else
        oc_d = sum_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      oc_q     <= '0;
`ifdef BMUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      oc_q     <= oc_d;
`ifdef BMUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign oC = oc_q;

endmodule

// File: tb/tb_bmul_seq.sv
// Scoreboard bench for bmul_seq: accepts push expected products, a monitor pops on handshake.
module tb_bmul_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iValid = 1'b0;
  logic          iReady = 1'b1;
  logic [W-1:0]  iA = '0;
  logic [W-1:0]  iB = '0;
`ifdef BMUL_SIGNED_EN
  logic          iSigned = 1'b0;
`endif
  logic          oReady, oValid;
  logic [PW-1:0] oC;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] expq[$];
  logic [PW-1:0] next_exp = '0;
  int            cyc = 0;
  int            acc_edge = 0;
  int            last_acc = 0;
  bit            has_prev = 1'b0;
  logic          valid_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bmul_seq #(.INWD(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .iValid  (iValid),
    .oReady  (oReady),
    .iA      (iA),
    .iB      (iB),
`ifdef BMUL_SIGNED_EN
    .iSigned (iSigned),
`endif
    .oValid  (oValid),
    .iReady  (iReady),
    .oC      (oC)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] model_u(input logic [W-1:0] a, input logic [W-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

`ifdef BMUL_SIGNED_EN
  function automatic logic [PW-1:0] model_s(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] sa, sb;
    sa = PW'($signed(a));
    sb = PW'($signed(b));
    return PW'(sa * sb);
  endfunction
`endif

  // Accept watcher: pushes the expected product and checks the initiation interval.
  always @(negedge clk) begin
    if (rst) begin
      has_prev = 1'b0;
    end else if (iValid && oReady) begin
      expq.push_back(next_exp);
      if (has_prev) check("interval_ge_w_plus_2", 32'((cyc + 1 - last_acc) >= int'(W + 2)), 32'd1);
      last_acc = cyc + 1;
      acc_edge = cyc + 1;
      has_prev = 1'b1;
    end
  end

  // Output monitor: latency, busy-ready and product comparison against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (oValid && !valid_prev) check("latency", 32'(cyc - acc_edge), 32'(W));
      if (expq.size() > 0 && cyc >= acc_edge && !oValid) check("oready_low_busy", 32'(oReady), 32'd0);
      if (oValid && iReady) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=0x%0h required=none at cycle %0d", oC, cyc);
        end else begin
          check("product", 32'(oC), 32'(expq.pop_front()));
        end
      end
    end
    valid_prev = oValid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] exp);
    bit ok = 1'b0;
    iA       = a;
    iB       = b;
    next_exp = exp;
    iValid   = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = oReady;
    end
    tick();
    iValid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && expq.size() > 0; i++) tick();
    check("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic random_stream();
    int sent = 0;
    bit fire;
    iValid = 1'b0;
    for (int c = 0; c < 20000 && sent < 100; c++) begin
      @(negedge clk);
      fire = iValid && oReady;
      tick();
      if (fire) sent++;
      if (!iValid || fire) begin
        iValid = ($urandom_range(1, 0) == 1) && (sent < 100);
        iA     = W'($urandom);
        iB     = W'($urandom);
`ifdef BMUL_SIGNED_EN
        iSigned  = 1'($urandom_range(1, 0));
        next_exp = iSigned ? model_s(iA, iB) : model_u(iA, iB);
`else
        next_exp = model_u(iA, iB);
`endif
      end
      iReady = 1'($urandom_range(1, 0));
    end
    iValid = 1'b0;
    iReady = 1'b1;
    drain();
    check("random_sent", 32'(sent), 32'd100);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    // Reset values, with ready forced low while rst is high.
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_oready", 32'(oReady), 32'd0);
    check("rst_ovalid", 32'(oValid), 32'd0);
    check("rst_oc", 32'(oC), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    send(8'd13, 8'd11, 16'h008F);
    drain();
    send(8'd255, 8'd255, 16'hFE01);
    drain();
    send(8'd0, 8'd200, 16'h0000);
    drain();

    // Backpressure: stall in DONE with new operands offered.
    iReady = 1'b0;
    send(8'd6, 8'd7, 16'd42);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = oValid;
    end
    check("bp_valid_seen", 32'(seen), 32'd1);
    iA       = 8'd3;
    iB       = 8'd4;
    next_exp = 16'd12;
    iValid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ovalid", 32'(oValid), 32'd1);
      check("bp_oc", 32'(oC), 32'd42);
      check("bp_oready", 32'(oReady), 32'd0);
      tick();
    end
    iReady = 1'b1;
    send(8'd3, 8'd4, 16'd12);
    drain();

    // Reset mid-BUSY, with iValid high on the reset edge.
    send(8'd9, 8'd9, 16'd81);
    tick();
    tick();
    rst    = 1'b1;
    iValid = 1'b1;
    iA     = 8'd5;
    iB     = 8'd5;
    expq.delete();
    tick();
    rst    = 1'b0;
    iValid = 1'b0;
    @(negedge clk);
    check("rstb_ovalid", 32'(oValid), 32'd0);
    check("rstb_oc", 32'(oC), 32'd0);
    check("rstb_oready", 32'(oReady), 32'd1);
    tick();
    send(8'd7, 8'd9, 16'd63);
    drain();

`ifdef BMUL_SIGNED_EN
    iSigned = 1'b1;
    send(8'hFD, 8'd5, 16'hFFF1);
    drain();
    send(8'h80, 8'h80, 16'h4000);
    drain();
    send(8'h7F, 8'h80, 16'hC080);
    drain();
    iSigned = 1'b0;
    send(8'hFD, 8'd5, 16'd1265);
    drain();
`endif

    random_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
